timebase_gen: RTL

Parametrised free-running timebase for the terminal design. Derives exact 1 ms and 1 s strobes from the system clock and maintains wrap-around millisecond and second counters. Includes one programmable millisecond timer (one-shot or periodic) with a start/stop/expire handshake. Consumers such as UI refresh, debounce and timeouts use the strobes and counters instead of running their own dividers.

---
 rtl/timebase_gen_if.sv | 31 +++
 rtl/timebase_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/timebase_gen_if.sv
// Bus between the timebase and its consumers: run/clear controls, strobes, counters and the
// millisecond-timer handshake.
interface timebase_gen_if #(
    parameter int unsigned MS_WIDTH = 15,
    parameter int unsigned S_WIDTH  = 8
);
    logic                en;
    logic                clr;
    logic                tick_ms;
    logic                tick_s;
    logic [MS_WIDTH-1:0] counter_ms;
    logic [S_WIDTH-1:0]  counter_s;
    logic                tmr_start;
    logic                tmr_stop;
    logic                tmr_periodic;
    logic [MS_WIDTH-1:0] tmr_period;
    logic                tmr_busy;
    logic                tmr_expired;

    // Consumer side: drives controls, observes strobes and counters
    modport master (
        output en, clr, tmr_start, tmr_stop, tmr_periodic, tmr_period,
        input  tick_ms, tick_s, counter_ms, counter_s, tmr_busy, tmr_expired
    );

    // Timebase side
    modport slave (
        input  en, clr, tmr_start, tmr_stop, tmr_periodic, tmr_period,
        output tick_ms, tick_s, counter_ms, counter_s, tmr_busy, tmr_expired
    );
endinterface

// File: rtl/timebase_gen.sv
// Free-running timebase: exact 1 ms / 1 s strobes, wrap-around ms and s counters, and one
// programmable millisecond timer (one-shot or periodic).
module timebase_gen #(
    parameter int unsigned CLK_HZ   = 25000000,
    parameter int unsigned MS_WIDTH = 15,
    parameter int unsigned S_WIDTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    timebase_gen_if.slave bus
);
    localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;
    localparam int unsigned PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CYC_PER_MS - 1);

    if (((CLK_HZ % 1000) != 0) || (CLK_HZ < 2000)) begin : g_bad_clk_hz
        $error("timebase_gen: CLK_HZ must be a multiple of 1000 and at least 2000");
    end

    typedef enum logic [0:0] {StIdle, StRun} tmr_state_e;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [9:0]          msin_q, msin_d;
    logic [MS_WIDTH-1:0] counter_ms_q, counter_ms_d;
    logic [S_WIDTH-1:0]  counter_s_q, counter_s_d;
    logic                tick_ms_q, tick_ms_d;
    logic                tick_s_q, tick_s_d;

    tmr_state_e          state_q, state_d;
    logic [MS_WIDTH-1:0] rem_q, rem_d;
    logic [MS_WIDTH-1:0] period_q, period_d;
    logic                periodic_q, periodic_d;
    logic                expired_q, expired_d;

    logic ms_evt;
    logic s_evt;
    logic start_ok;

    assign ms_evt   = bus.en & ~bus.clr & (pre_q == PRE_MAX);
    assign s_evt    = ms_evt & (msin_q == 10'd999);
    assign start_ok = bus.tmr_start & (bus.tmr_period != '0);

    // Timebase next state: clr beats en, en low freezes everything
    always_comb begin
        pre_d        = pre_q;
        msin_d       = msin_q;
        counter_ms_d = counter_ms_q;
        counter_s_d  = counter_s_q;
        tick_ms_d    = ms_evt;
        tick_s_d     = s_evt;
        if (bus.clr) begin
            pre_d        = '0;
            msin_d       = '0;
            counter_ms_d = '0;
            counter_s_d  = '0;
        end else if (bus.en) begin
            if (ms_evt) begin
                pre_d        = '0;
                counter_ms_d = counter_ms_q + MS_WIDTH'(1);
                if (s_evt) begin
                    msin_d      = '0;
                    counter_s_d = counter_s_q + S_WIDTH'(1);
                end else begin
                    msin_d = msin_q + 10'd1;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Timebase registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            msin_q       <= '0;
            counter_ms_q <= '0;
            counter_s_q  <= '0;
            tick_ms_q    <= 1'b0;
            tick_s_q     <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            msin_q       <= msin_d;
            counter_ms_q <= counter_ms_d;
            counter_s_q  <= counter_s_d;
            tick_ms_q    <= tick_ms_d;
            tick_s_q     <= tick_s_d;
        end
    end

    // Timer FSM: stop beats start, start beats a coincident ms event
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        expired_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.tmr_stop && start_ok) begin
                    state_d    = StRun;
                    rem_d      = bus.tmr_period;
                    period_d   = bus.tmr_period;
                    periodic_d = bus.tmr_periodic;
                end
            end
            StRun: begin
                if (bus.tmr_stop) begin
                    state_d = StIdle;
                end else if (start_ok) begin
                    rem_d      = bus.tmr_period;
                    period_d   = bus.tmr_period;
                    periodic_d = bus.tmr_periodic;
                end else if (ms_evt) begin
                    if (rem_q == MS_WIDTH'(1)) begin
                        expired_d = 1'b1;
                        if (periodic_q) begin
                            rem_d = period_q;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        rem_d = rem_q - MS_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Timer registers; not affected by clr
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            expired_q  <= expired_d;
        end
    end

    assign bus.tick_ms     = tick_ms_q;
    assign bus.tick_s      = tick_s_q;
    assign bus.counter_ms  = counter_ms_q;
    assign bus.counter_s   = counter_s_q;
    assign bus.tmr_busy    = (state_q == StRun);
    assign bus.tmr_expired = expired_q;

endmodule
